// File: rtl/serdes_tx_sched.sv
// serdes_tx_sched: round-robin frame scheduler in front of the LVDS serializer.
// Define SERDES_TX_SCHED_TRAIN_EN to compile in periodic link-training bursts.
module serdes_tx_sched #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned IFG          = 2,
  parameter int unsigned TRAIN_PERIOD = 1024,
  parameter int unsigned TRAIN_LEN    = 4,
  parameter logic [31:0] TRAIN_WORD   = 32'hBC50BC50,
  parameter logic [31:0] FLAG_WORD    = 32'h7E7E7E7E
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  output logic [1:0]          serd_cmd,
  output logic [31:0]         din,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
);

  localparam int unsigned PW = $clog2(N_REQ);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_FLAG  = 2'b01;
  localparam logic [1:0] CMD_DATA  = 2'b10;
  localparam logic [1:0] CMD_TRAIN = 2'b11;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_DATA,
    ST_CLOSE,
    ST_GAP,
    ST_TRAIN
  } state_e;

  if (N_REQ < 2 || N_REQ > 8 || IFG < 1 || IFG > 15 || TRAIN_PERIOD < 16 ||
      TRAIN_LEN < 1 || TRAIN_LEN > 15 || TRAIN_WORD == FLAG_WORD) begin : g_bad_param
    $error("serdes_tx_sched: parameter out of range");
  end

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    gidx_q;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       cmd_q;
  logic [31:0]      din_q;
  logic             busy_q;
  logic [3:0]       gap_q;

  logic             pick_vld;
  logic [PW-1:0]    pick_idx;
  int unsigned      cand;
  logic [31:0]      gdata;
  logic             gvalid;
  logic             glast;

`ifdef SERDES_TX_SCHED_TRAIN_EN
  localparam int unsigned CW = $clog2(TRAIN_PERIOD);
  logic [CW-1:0] pcnt_q;
  logic          pend_q;
  logic [3:0]    tcnt_q;
`endif

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  assign gdata  = req_data[32*gidx_q +: 32];
  assign gvalid = req_valid[gidx_q];
  assign glast  = req_last[gidx_q];

  assign req_ready = (state_q == ST_DATA) ? grant_q : '0;
  assign serd_cmd  = cmd_q;
  assign din       = din_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

  // Each state emits the word shown on the next cycle, so the last GAP or TRAIN
  // cycle already hands over to ARB and a waiting request opens with no extra idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cmd_q   <= CMD_IDLE;
      din_q   <= '0;
      busy_q  <= 1'b0;
      gap_q   <= '0;
`ifdef SERDES_TX_SCHED_TRAIN_EN
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
      tcnt_q  <= '0;
`endif
    end else begin
`ifdef SERDES_TX_SCHED_TRAIN_EN
      if (pcnt_q != CW'(TRAIN_PERIOD - 1)) pcnt_q <= pcnt_q + 1'b1;
      else                                  pend_q <= 1'b1;
`endif
      case (state_q)
        ST_ARB: begin
`ifdef SERDES_TX_SCHED_TRAIN_EN
          if (pend_q) begin
            cmd_q  <= CMD_TRAIN;
            din_q  <= TRAIN_WORD;
            busy_q <= 1'b1;
            if (TRAIN_LEN > 1) begin
              state_q <= ST_TRAIN;
              tcnt_q  <= 4'(TRAIN_LEN - 2);
            end else begin
              pend_q <= 1'b0;
              pcnt_q <= '0;
            end
          end else
`endif
          if (pick_vld) begin
            state_q <= ST_DATA;
            gidx_q  <= pick_idx;
            grant_q <= N_REQ'(1) << pick_idx;
            cmd_q   <= CMD_FLAG;
            din_q   <= FLAG_WORD;
            busy_q  <= 1'b1;
          end else begin
            cmd_q  <= CMD_IDLE;
            din_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        ST_DATA: begin
          busy_q <= 1'b1;
          if (gvalid) begin
            cmd_q <= CMD_DATA;
            din_q <= gdata;
            if (glast) state_q <= ST_CLOSE;
          end else begin
            cmd_q <= CMD_IDLE;
            din_q <= '0;
          end
        end
        ST_CLOSE: begin
          cmd_q   <= CMD_FLAG;
          din_q   <= FLAG_WORD;
          busy_q  <= 1'b1;
          grant_q <= '0;
          ptr_q   <= (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
          gap_q   <= 4'(IFG - 1);
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          cmd_q  <= CMD_IDLE;
          din_q  <= '0;
          busy_q <= 1'b0;
          if (gap_q == '0) state_q <= ST_ARB;
          else             gap_q   <= gap_q - 1'b1;
        end
`ifdef SERDES_TX_SCHED_TRAIN_EN
        ST_TRAIN: begin
          cmd_q  <= CMD_TRAIN;
          din_q  <= TRAIN_WORD;
          busy_q <= 1'b1;
          if (tcnt_q == '0) begin
            state_q <= ST_ARB;
            pend_q  <= 1'b0;
            pcnt_q  <= '0;
          end else begin
            tcnt_q <= tcnt_q - 1'b1;
          end
        end
`endif
        default: state_q <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// Directed bench for serdes_tx_sched (N_REQ=2, IFG=2); training checks use a
// second instance and are built only with SERDES_TX_SCHED_TRAIN_EN.
module tb_serdes_tx_sched;

  localparam logic [31:0] FW = 32'h7E7E7E7E;
  localparam logic [31:0] TW = 32'hBC50BC50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [1:0]  serd_cmd;
  logic [31:0] din;
  logic [1:0]  grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serdes_tx_sched #(.N_REQ(2), .IFG(2), .TRAIN_PERIOD(1024), .TRAIN_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .serd_cmd(serd_cmd), .din(din),
    .grant(grant), .busy(busy)
  );

`ifdef SERDES_TX_SCHED_TRAIN_EN
  logic [1:0]  t_ready;
  logic [1:0]  t_cmd;
  logic [31:0] t_din;
  logic [1:0]  t_grant;
  logic        t_busy;

  serdes_tx_sched #(.N_REQ(2), .IFG(2), .TRAIN_PERIOD(16), .TRAIN_LEN(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(t_ready), .serd_cmd(t_cmd), .din(t_din),
    .grant(t_grant), .busy(t_busy)
  );
`endif

  function automatic logic [31:0] wd(input int r, input int s);
    return 32'hD000_0000 | (32'(r) << 16) | 32'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (serd_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_cmd got %h want 0", serd_cmd); end
    if (din !== 32'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", din); end
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", req_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [31:0] w [3];
    logic [38:0] exp [7];
    logic [38:0] got;
    int idx = 0;
    logic acc;
    w[0] = 32'hA1A1_0001; w[1] = 32'hA2A2_0002; w[2] = 32'hA3A3_0003;
    exp[0] = {2'b01, FW,   2'b01, 1'b1, 2'b01};
    exp[1] = {2'b10, w[0], 2'b01, 1'b1, 2'b01};
    exp[2] = {2'b10, w[1], 2'b01, 1'b1, 2'b01};
    exp[3] = {2'b10, w[2], 2'b01, 1'b1, 2'b00};
    exp[4] = {2'b01, FW,   2'b00, 1'b1, 2'b00};
    exp[5] = {2'b00, 32'h0, 2'b00, 1'b0, 2'b00};
    exp[6] = {2'b00, 32'h0, 2'b00, 1'b0, 2'b00};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid[0]     = (idx < 3);
      req_data[31:0]   = (idx < 3) ? w[idx] : 32'h0;
      req_last[0]      = (idx == 2);
      acc = req_valid[0] & req_ready[0];
      tick();
      if (acc) idx++;
      got = {serd_cmd, din, grant, busy, req_ready};
      n_tests++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL single_frame cycle %0d got %h want %h", c + 1, got, exp[c]);
      end
    end
  endtask

  task automatic test_fairness();
    int seq [2];
    logic [1:0] acc;
    logic [36:0] exp;
    logic [36:0] got;
    int pos, f, g;
    seq[0] = 0; seq[1] = 0;
    apply_reset();
    for (int i = 1; i <= 24; i++) begin
      for (int r = 0; r < 2; r++) begin
        req_valid[r]         = 1'b1;
        req_data[32*r +: 32] = wd(r, seq[r]);
        req_last[r]          = seq[r][0];
        acc[r]               = req_ready[r];
      end
      tick();
      for (int r = 0; r < 2; r++) if (acc[r]) seq[r]++;
      pos = (i - 1) % 6;
      f   = (i - 1) / 6;
      g   = f % 2;
      case (pos)
        0:       exp = {2'b01, FW, 2'(1 << g), 1'b1};
        1, 2:    exp = {2'b10, wd(g, 2 * (f / 2) + pos - 1), 2'(1 << g), 1'b1};
        3:       exp = {2'b01, FW, 2'b00, 1'b1};
        default: exp = {2'b00, 32'h0, 2'b00, 1'b0};
      endcase
      got = {serd_cmd, din, grant, busy};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fairness cycle %0d got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_underflow();
    logic [36:0] exp [11];
    logic [36:0] got;
    int idx = 0;
    logic acc;
    exp[0]  = {2'b01, FW,          2'b01, 1'b1};
    exp[1]  = {2'b10, wd(0, 16),   2'b01, 1'b1};
    exp[2]  = {2'b10, wd(0, 17),   2'b01, 1'b1};
    exp[3]  = {2'b00, 32'h0,       2'b01, 1'b1};
    exp[4]  = {2'b00, 32'h0,       2'b01, 1'b1};
    exp[5]  = {2'b10, wd(0, 18),   2'b01, 1'b1};
    exp[6]  = {2'b10, wd(0, 19),   2'b01, 1'b1};
    exp[7]  = {2'b01, FW,          2'b00, 1'b1};
    exp[8]  = {2'b00, 32'h0,       2'b00, 1'b0};
    exp[9]  = {2'b00, 32'h0,       2'b00, 1'b0};
    exp[10] = {2'b01, FW,          2'b10, 1'b1};
    apply_reset();
    req_valid[1]    = 1'b1;
    req_data[63:32] = wd(1, 119);
    req_last[1]     = 1'b1;
    for (int c = 0; c < 11; c++) begin
      req_valid[0]   = (idx < 4) && !(c == 3 || c == 4);
      req_data[31:0] = wd(0, 16 + idx);
      req_last[0]    = (idx == 3);
      acc = req_valid[0] & req_ready[0];
      n_tests++;
      if (req_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL underflow_ready1 cycle %0d got %b want 0", c, req_ready[1]);
      end
      tick();
      if (acc) idx++;
      got = {serd_cmd, din, grant, busy};
      n_tests++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL underflow cycle %0d got %h want %h", c + 1, got, exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [36:0] got;
    logic [38:0] got_r;
    apply_reset();
    req_data[31:0]  = wd(0, 1);
    req_last[0]     = 1'b1;
    req_data[63:32] = wd(1, 2);
    req_last[1]     = 1'b0;
    for (int c = 0; c < 7; c++) begin
      req_valid[0] = (c < 2);
      req_valid[1] = (c >= 2);
      tick();
    end
    got = {serd_cmd, din, grant, busy};
    n_tests++;
    if (got !== {2'b10, wd(1, 2), 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset_frame got %h want %h", got, {2'b10, wd(1, 2), 2'b10, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    got_r = {serd_cmd, din, grant, busy, req_ready};
    n_tests++;
    if (got_r !== 39'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs got %h want 0", got_r);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    tick();
    got = {serd_cmd, din, grant, busy};
    n_tests++;
    if (got !== {2'b01, FW, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_first_frame got %h want %h", got, {2'b01, FW, 2'b01, 1'b1});
    end
  endtask

`ifdef SERDES_TX_SCHED_TRAIN_EN
  task automatic test_train();
    logic [36:0] exp;
    logic [36:0] got;
    apply_reset();
    for (int e = 1; e <= 61; e++) begin
      if (e == 57) begin
        req_valid[0]   = 1'b1;
        req_data[31:0] = wd(0, 5);
        req_last[0]    = 1'b1;
      end
      tick();
      if ((e >= 17 && e <= 20) || (e >= 37 && e <= 40) || (e >= 57 && e <= 60))
        exp = {2'b11, TW, 2'b00, 1'b1};
      else if (e == 61)
        exp = {2'b01, FW, 2'b01, 1'b1};
      else
        exp = {2'b00, 32'h0, 2'b00, 1'b0};
      got = {t_cmd, t_din, t_grant, t_busy};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL train cycle %0d got %h want %h", e, got, exp);
      end
    end
  endtask
`else
  task automatic test_random_traffic();
    logic [1:0]  acc;
    logic        acc_any;
    logic [31:0] acc_word;
    logic        acc_last;
    logic        open = 1'b0;
    logic        last_seen = 1'b0;
    int          frames = 0;
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int r = 0; r < 2; r++) begin
        req_valid[r]         = ($urandom_range(3) != 0);
        req_data[32*r +: 32] = $urandom;
        req_last[r]          = ($urandom_range(3) == 0);
        acc[r]               = req_valid[r] & req_ready[r];
      end
      acc_any  = |acc;
      acc_word = acc[1] ? req_data[63:32] : req_data[31:0];
      acc_last = acc[1] ? req_last[1] : req_last[0];
      tick();
      n_tests++;
      if (serd_cmd === 2'b11) begin
        n_fail++;
        $display("FAIL rand_no_train cycle %0d got %b want not 11", c, serd_cmd);
      end
      n_tests++;
      if ((serd_cmd === 2'b10) !== acc_any ||
          (acc_any && (din !== acc_word || !open))) begin
        n_fail++;
        $display("FAIL rand_data cycle %0d got cmd %b din %h want data %b din %h in frame",
                 c, serd_cmd, din, acc_any, acc_word);
      end
      if (acc_any) last_seen = acc_last;
      if (serd_cmd === 2'b01) begin
        if (!open) begin
          open = 1'b1;
          last_seen = 1'b0;
        end else begin
          open = 1'b0;
          frames++;
          n_tests++;
          if (last_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_close cycle %0d got last %b want 1", c, last_seen);
          end
        end
      end
    end
    n_tests++;
    if (frames < 100) begin
      n_fail++;
      $display("FAIL rand_frame_count got %0d want at least 100", frames);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_fairness();
    test_underflow();
    test_reset_mid_frame();
`ifdef SERDES_TX_SCHED_TRAIN_EN
    test_train();
`else
    test_random_traffic();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got no completion want finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
